// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
//   Shared definitions for the data-memory access controller:
//   - access size encodings carried on req_size
//   - FSM state encoding
//   - alignment check helper used at request acceptance
package mem_access_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RMW_WRITE = 2'd2
  } state_e;

  // Returns 1 when the access cannot be performed: halfword on an odd byte,
  // word not on a 4-byte boundary, or the reserved size code.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit
//   Purely combinational lane logic for a little-endian 32-bit word RAM.
//   Ports:
//     ld_word     in  32  raw RAM word for a load
//     ld_lane     in   2  byte address bits [1:0] of the load
//     ld_size     in   2  access size (byte/half/word)
//     ld_unsigned in   1  1 = zero-extend, 0 = sign-extend
//     ld_data     out 32  selected lane, extended to 32 bits
//     st_old      in  32  current RAM word for a sub-word store
//     st_wdata    in  32  right-aligned store data
//     st_lane     in   2  byte address bits [1:0] of the store
//     st_size     in   2  access size
//     st_data     out 32  old word with the target lane replaced
module mem_lane_unit
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_lane,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  output logic [31:0] ld_data,
  input  logic [31:0] st_old,
  input  logic [31:0] st_wdata,
  input  logic [1:0]  st_lane,
  input  logic [1:0]  st_size,
  output logic [31:0] st_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        byte_sign_s;
  logic        half_sign_s;

  // Load path: pick the addressed lane and extend it to 32 bits.
  always_comb begin
    byte_s      = 8'h00;
    half_s      = 16'h0000;
    byte_sign_s = 1'b0;
    half_sign_s = 1'b0;
    ld_data     = 32'h0000_0000;
    case (ld_lane)
      2'b00:   byte_s = ld_word[7:0];
      2'b01:   byte_s = ld_word[15:8];
      2'b10:   byte_s = ld_word[23:16];
      2'b11:   byte_s = ld_word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (ld_lane[1]) begin
      half_s = ld_word[31:16];
    end else begin
      half_s = ld_word[15:0];
    end
    byte_sign_s = ~ld_unsigned & byte_s[7];
    half_sign_s = ~ld_unsigned & half_s[15];
    case (ld_size)
      SZ_BYTE: ld_data = {{24{byte_sign_s}}, byte_s};
      SZ_HALF: ld_data = {{16{half_sign_s}}, half_s};
      SZ_WORD: ld_data = ld_word;
      default: ld_data = 32'h0000_0000;
    endcase
  end

  // Store path: overwrite only the addressed lane of the old word.
  always_comb begin
    st_data = st_old;
    case (st_size)
      SZ_BYTE: begin
        case (st_lane)
          2'b00:   st_data[7:0]   = st_wdata[7:0];
          2'b01:   st_data[15:8]  = st_wdata[7:0];
          2'b10:   st_data[23:16] = st_wdata[7:0];
          2'b11:   st_data[31:24] = st_wdata[7:0];
          default: st_data        = st_old;
        endcase
      end
      SZ_HALF: begin
        if (st_lane[1]) begin
          st_data[31:16] = st_wdata[15:0];
        end else begin
          st_data[15:0]  = st_wdata[15:0];
        end
      end
      SZ_WORD: st_data = st_wdata;
      default: st_data = st_old;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   MEM-stage initiator for a synchronous word-wide data RAM. Converts
//   byte/half/word loads and stores into RAM cycles: loads take two cycles,
//   sub-word stores do a read-modify-write, word stores and illegal requests
//   complete in one cycle. One request outstanding at a time.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     req_valid/write/size/unsigned/addr/wdata   pipeline request
//     ready                    request can be accepted this cycle
//     rsp_valid/rdata/err      completion pulse, load data, alignment error
//     mem_addr/wdata/read/write  RAM control (word address)
//     mem_rdata                RAM read data, valid the cycle after mem_read
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_read,
  output logic              mem_write
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          lane_q, lane_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;

  logic [31:0]         ld_data_s;
  logic [31:0]         st_data_s;
  logic                addr_hi_unused;

  // Upper address bits do not reach the RAM; accesses wrap modulo its size.
  assign addr_hi_unused = ^req_addr[31:ADDR_W+2];

  mem_lane_unit u_lane (
    .ld_word     (mem_rdata),
    .ld_lane     (lane_q),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .ld_data     (ld_data_s),
    .st_old      (mem_rdata),
    .st_wdata    (wdata_q),
    .st_lane     (lane_q),
    .st_size     (size_q),
    .st_data     (st_data_s)
  );

  // Next-state, request latch, response and RAM drive logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    lane_d      = lane_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    ready       = 1'b0;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    case (state_q)
      IDLE: begin
        // RAM is driven straight from the request so a word store or the
        // first read of a load/RMW happens in the acceptance cycle.
        ready     = ~rst;
        mem_addr  = req_addr[ADDR_W+1:2];
        mem_wdata = req_wdata;
        if (req_valid && !rst) begin
          addr_d  = req_addr[ADDR_W+1:2];
          lane_d  = req_addr[1:0];
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0000_0000;
          end else if (req_write && (req_size == SZ_WORD)) begin
            mem_write   = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 32'h0000_0000;
          end else begin
            mem_read = 1'b1;
            if (req_write) begin
              state_d = RMW_WRITE;
            end else begin
              state_d = LOAD_WAIT;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = ld_data_s;
        state_d     = IDLE;
      end
      RMW_WRITE: begin
        // Reset in this cycle must not leave a half-finished store behind.
        mem_write   = ~rst;
        mem_wdata   = st_data_s;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      lane_q      <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the data-memory interface.
- Sits in the MEM stage between the pipeline and the synchronous word-wide data RAM (11-bit word address, registered read, write on clock edge).
- Turns byte/halfword/word load and store requests into RAM read/write cycles: lane extraction with sign/zero extension for loads, read-modify-write for sub-word stores, and alignment checks.
- Single outstanding request; `ready` low stalls the pipeline.

Parameters:
- ADDR_W, 11, RAM word-address width; byte address window is 2^(ADDR_W+2) bytes.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- ready  out  1  block can accept a request this cycle
- rsp_valid  out  1  one-cycle pulse: request completed
- rsp_rdata  out  32  extended load data (0 for stores and errors)
- rsp_err  out  1  alignment/size error, qualified by rsp_valid
- mem_addr  out  ADDR_W  word address to RAM = req_addr[ADDR_W+1:2]
- mem_wdata  out  32  data to RAM data input
- mem_rdata  in  32  RAM data output, valid the cycle after mem_read
- mem_read  out  1  RAM read enable
- mem_write  out  1  RAM write enable

Behaviour:
- **Byte order.** Little-endian lanes: byte lane = addr[1:0], lane 0 = bits [7:0]; halfword lane = addr[1], lane 0 = bits [15:0].
- **Address range.** req_addr bits above ADDR_W+1 are ignored; accesses wrap modulo the RAM.
- **States.**
  - IDLE: ready = 1.
  - LOAD_WAIT, RMW_WRITE: ready = 0.
- **Acceptance.** A request is accepted when req_valid && ready. When ready = 0, req_valid is ignored and the requester holds its request.
- **Request latch.** On acceptance, addr lane, size, unsigned and wdata are latched.
- **IDLE memory drive.** In IDLE, mem_addr/mem_read/mem_write/mem_wdata are driven combinationally from the request; all other states drive them from the latched request.
- **Illegal requests.** Misaligned means: half with addr[0] = 1, word with addr[1:0] ≠ 0, or size = 11.
  - No RAM access.
  - rsp_valid = 1, rsp_err = 1, rsp_rdata = 0 in cycle T+1.
  - Stay in IDLE.
- **Word store.**
  - Accept cycle T: mem_write = 1, mem_wdata = req_wdata.
  - rsp_valid in T+1; stay in IDLE, so back-to-back word stores run at 1 per cycle.
- **Load (any size).**
  - T: mem_read = 1, go to LOAD_WAIT.
  - T+1: extract the lane from mem_rdata and extend it; register into rsp_rdata with rsp_valid = 1 in T+2; return to IDLE (ready in T+2).
- **Sub-word store.**
  - T: mem_read = 1, go to RMW_WRITE.
  - T+1: mem_write = 1, mem_wdata = mem_rdata with the target lane replaced by the latched wdata; return to IDLE.
  - rsp_valid in T+2, rsp_rdata = 0.
- **Response registers.** rsp_valid is a registered one-cycle pulse. rsp_rdata and rsp_err hold their values until the next response.
- **Reset.**
  - rst dominates any state: next state IDLE; rsp_valid, rsp_err and rsp_rdata clear to 0.
  - mem_read, mem_write and ready are forced to 0 during any cycle with rst = 1.
  - A reset in RMW_WRITE therefore suppresses the write: no partial store.
- **Concurrency.** rsp_valid for request N may coincide with acceptance of request N+1.

Decomposition:
- Shared package holds:
  - size encodings (SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10);
  - state encodings (IDLE, LOAD_WAIT, RMW_WRITE).
- One combinational sub-module, mem_lane_unit, provides:
  - load extract/extend (word, lane, size, unsigned → 32-bit);
  - store merge (old word, wdata, lane, size → 32-bit).
- The FSM and registers stay in mem_access_ctrl.

Test Plan:
- Word store 0xDEADBEEF to addr 0x10 at T → mem_write = 1 and mem_addr = 4 at T; rsp_valid at T+1, err = 0; a following word load of 0x10 returns 0xDEADBEEF at accept + 2.
- RAM word 4 = 0x8081F27F; byte loads of 0x10..0x13 signed → 0x0000007F, 0xFFFFFFF2, 0xFFFFFF81, 0xFFFFFF80; unsigned byte of 0x12 → 0x00000081; signed half of 0x12 → 0xFFFF8081.
- Word 4 = 0x11223344; store byte 0xAA to 0x11 → T+1 mem_wdata = 0x1122AA44, rsp_valid at T+2; store half 0xBEEF to 0x12 → 0xBEEFAA44.
- Misaligned: half load at 0x13, word store at 0x12, size = 11 → no mem_read/mem_write, rsp_valid + rsp_err at T+1, rdata = 0.
- Assert rst during RMW_WRITE of a byte store → mem_write stays 0, RAM word unchanged, next cycle IDLE with ready = 1 and rsp_valid = 0.
- req_valid held high during LOAD_WAIT with a different address → ignored until ready; exactly one rsp_valid per accepted request, in order.
